hilo_muldiv_sequencer: RTL and testbench

Multi-cycle controller that owns every update to the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and sequences a pipelined multiplier or an iterative restoring divider. It emits single-cycle write_hi/write_lo pulses with data, which the pipeline carries back to the decode-stage HI/LO registers. It also raises a pipeline stall while a result is pending and a consumer needs HI/LO.

---
 rtl/hilo_muldiv_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_hilo_muldiv_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_sequencer.sv
// rtl/hilo_muldiv_sequencer.sv - HI/LO update sequencer for MULT/DIV/MTHI/MTLO
//
// Owns every write to the HI/LO pair. Multiplies finish MUL_LATENCY cycles
// after acceptance; divides run a 32-step restoring divider and finish 33
// cycles after acceptance. Results leave as one-cycle write_hi/write_lo pulses.
//
// Optional feature macro: HILO_MADD_EN (enables MADD/MADDU/MSUB/MSUBU, ops 6-9).
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   start, op               operation valid / opcode (0..5, 6..9 with macro)
//   rs_data, rt_data        operands
//   hi_in, lo_in            forwarded HI/LO (accumulate ops only)
//   flush                   cancel in-flight operation, drop same-cycle start
//   read_hilo               consumer in decode/execute reads HI/LO
//   busy                    operation in flight (registered)
//   stall                   busy & (start | read_hilo) (combinational)
//   write_hi, write_lo      one-cycle write pulses
//   hi_data, lo_data        write data
module hilo_muldiv_sequencer #(
    parameter int MUL_LATENCY = 3,
    parameter int DIV_ITER    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        flush,
    input  logic        read_hilo,
    output logic        busy,
    output logic        stall,
    output logic        write_hi,
    output logic        write_lo,
    output logic [31:0] hi_data,
    output logic [31:0] lo_data
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    state_t      state, next_state;
    logic [3:0]  mcnt;
    logic [4:0]  dcnt;
    logic [31:0] res_hi, res_lo;
    logic [31:0] rem, quo, dvs, dz_hi;
    logic        neg_q, neg_r, dz;

    logic op_mul, op_div, op_mthi, op_mtlo, op_signed;
    logic accept, mul_last, div_last;

    assign op_div    = (op == 4'd2) || (op == 4'd3);
    assign op_mthi   = (op == 4'd4);
    assign op_mtlo   = (op == 4'd5);
    assign op_signed = (op == 4'd0) || (op == 4'd2) || (op == 4'd6) || (op == 4'd8);

    // FIN is the divide write-pulse cycle; busy is already low there, so a
    // new start is accepted exactly as in IDLE.
    assign accept   = start && !busy && !flush;
    assign mul_last = (state == S_MUL) && (mcnt == 4'(MUL_LATENCY - 1));
    assign div_last = (state == S_DIV) && (dcnt == 5'(DIV_ITER - 1));
    assign stall    = busy && (start || read_hilo);

    // Multiply: low 64 bits of a 64x64 product of sign- or zero-extended
    // operands give the exact signed or unsigned result.
    logic [63:0] prod_s, prod_u, prod, mul_res;
    assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};
    assign prod   = op_signed ? prod_s : prod_u;

`ifdef HILO_MADD_EN
    assign op_mul  = (op <= 4'd1) || ((op >= 4'd6) && (op <= 4'd9));
    always_comb begin
        mul_res = prod;
        if (op == 4'd6 || op == 4'd7)
            mul_res = {hi_in, lo_in} + prod;
        else if (op == 4'd8 || op == 4'd9)
            mul_res = {hi_in, lo_in} - prod;
    end
`else
    logic unused_acc;
    assign op_mul     = (op <= 4'd1);
    assign mul_res    = prod;
    assign unused_acc = ^{hi_in, lo_in};
`endif

    // Divider operand magnitudes and result sign flags.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    assign a_neg = op_signed && rs_data[31];
    assign b_neg = op_signed && rt_data[31];
    assign a_mag = a_neg ? (32'd0 - rs_data) : rs_data;
    assign b_mag = b_neg ? (32'd0 - rt_data) : rt_data;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract when it does not borrow.
    logic [32:0] part;
    logic [33:0] diff;
    logic [31:0] rem_n, quo_n, q_fin, r_fin;
    assign part  = {rem, quo[31]};
    assign diff  = {1'b0, part} - {2'b00, dvs};
    assign rem_n = diff[33] ? part[31:0] : diff[31:0];
    assign quo_n = {quo[30:0], ~diff[33]};
    assign q_fin = neg_q ? (32'd0 - quo_n) : quo_n;
    assign r_fin = neg_r ? (32'd0 - rem_n) : rem_n;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_FIN: begin
                next_state = S_IDLE;
                if (accept && op_mul && (MUL_LATENCY > 1)) next_state = S_MUL;
                else if (accept && op_div)                 next_state = S_DIV;
            end
            S_MUL:   if (flush || mul_last) next_state = S_IDLE;
            S_DIV:   if (flush) next_state = S_IDLE;
                     else if (div_last) next_state = S_FIN;
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    logic        wh_n, wl_n, busy_n;
    logic [31:0] hd_n, ld_n;
    always_comb begin
        wh_n   = 1'b0;
        wl_n   = 1'b0;
        hd_n   = hi_data;
        ld_n   = lo_data;
        busy_n = (next_state == S_MUL) || (next_state == S_DIV);
        if (!flush) begin
            if (mul_last) begin
                {wh_n, wl_n} = 2'b11;
                hd_n = res_hi;
                ld_n = res_lo;
            end else if (div_last) begin
                {wh_n, wl_n} = 2'b11;
                hd_n = dz ? dz_hi : r_fin;
                ld_n = dz ? 32'hFFFF_FFFF : q_fin;
            end else if (accept) begin
                if (op_mthi) begin
                    wh_n = 1'b1;
                    hd_n = rs_data;
                end
                if (op_mtlo) begin
                    wl_n = 1'b1;
                    ld_n = rs_data;
                end
                if (op_mul && (MUL_LATENCY == 1)) begin
                    {wh_n, wl_n} = 2'b11;
                    hd_n = mul_res[63:32];
                    ld_n = mul_res[31:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            write_hi <= 1'b0;
            write_lo <= 1'b0;
            hi_data  <= 32'd0;
            lo_data  <= 32'd0;
        end else begin
            busy     <= busy_n;
            write_hi <= wh_n;
            write_lo <= wl_n;
            hi_data  <= hd_n;
            lo_data  <= ld_n;
        end
    end

    // Datapath: operand capture at acceptance, then per-cycle progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcnt   <= 4'd0;
            dcnt   <= 5'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            rem    <= 32'd0;
            quo    <= 32'd0;
            dvs    <= 32'd0;
            dz_hi  <= 32'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else if (accept) begin
            mcnt <= 4'd1;
            dcnt <= 5'd0;
            if (op_mul) begin
                res_hi <= mul_res[63:32];
                res_lo <= mul_res[31:0];
            end
            if (op_div) begin
                rem   <= 32'd0;
                quo   <= a_mag;
                dvs   <= b_mag;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                dz    <= (rt_data == 32'd0);
                dz_hi <= rs_data;
            end
        end else if (state == S_MUL) begin
            mcnt <= mcnt + 4'd1;
        end else if (state == S_DIV) begin
            rem  <= rem_n;
            quo  <= quo_n;
            dcnt <= dcnt + 5'd1;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// tb/tb_hilo_muldiv_sequencer.sv - scoreboard bench for hilo_muldiv_sequencer
module tb_hilo_muldiv_sequencer;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset, start, flush, read_hilo;
    logic [3:0]  op;
    logic [31:0] rs_data, rt_data, hi_in, lo_in;
    logic        busy, stall, write_hi, write_lo;
    logic [31:0] hi_data, lo_data;

    hilo_muldiv_sequencer #(.MUL_LATENCY(LAT), .DIV_ITER(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .hi_in(hi_in), .lo_in(lo_in),
        .flush(flush), .read_hilo(read_hilo),
        .busy(busy), .stall(stall), .write_hi(write_hi), .write_lo(write_lo),
        .hi_data(hi_data), .lo_data(lo_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          wh;
        bit          wl;
        logic [31:0] h;
        logic [31:0] l;
    } exp_t;

    exp_t q[$];
    int   busy_from = 1;
    int   busy_to   = 0;
    int   free_at   = 0;
    int   total     = 0;
    int   bad       = 0;
    bit   rand_rd   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: architectural result of each op. kind 0 none, 1 HI, 2 LO,
    // 3 multiply class, 4 divide class.
    function automatic void model(input logic [3:0] o, input logic [31:0] a, b, h, l,
                                  output int kind, output logic [31:0] rh, rl);
        longint      sa, sb, qq, rr;
        logic [63:0] p, acc;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        acc  = {h, l};
        kind = 0;
        rh   = 32'd0;
        rl   = 32'd0;
        p    = 64'd0;
        case (o)
            4'd0: begin p = sa * sb; kind = 3; end
            4'd1: begin p = {32'd0, a} * {32'd0, b}; kind = 3; end
            4'd2, 4'd3: begin
                kind = 4;
                if (b == 32'd0) begin
                    rl = 32'hFFFF_FFFF;
                    rh = a;
                end else if (o == 4'd2) begin
                    qq = sa / sb;
                    rr = sa % sb;
                    rl = 32'(qq);
                    rh = 32'(rr);
                end else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
            4'd4: begin kind = 1; rh = a; end
            4'd5: begin kind = 2; rl = a; end
`ifdef HILO_MADD_EN
            4'd6: begin p = acc + 64'(sa * sb); kind = 3; end
            4'd7: begin p = acc + {32'd0, a} * {32'd0, b}; kind = 3; end
            4'd8: begin p = acc - 64'(sa * sb); kind = 3; end
            4'd9: begin p = acc - {32'd0, a} * {32'd0, b}; kind = 3; end
`endif
            default: kind = 0;
        endcase
        if (kind == 3) begin
            rh = p[63:32];
            rl = p[31:0];
        end
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
        read_hilo = rand_rd ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    // Holds start until the model says busy is low, then records the
    // expected pulses for the accepting cycle.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, b, h, l);
        int          kind, t;
        logic [31:0] rh, rl;
        op = o; rs_data = a; rt_data = b; hi_in = h; lo_in = l;
        start = 1'b1;
        while (cyc < free_at) next();
        t = cyc;
        model(o, a, b, h, l, kind, rh, rl);
        case (kind)
            1: begin q.push_back('{t + 1, 1'b1, 1'b0, rh, rl}); free_at = t + 1; end
            2: begin q.push_back('{t + 1, 1'b0, 1'b1, rh, rl}); free_at = t + 1; end
            3: begin
                busy_from = t + 1; busy_to = t + LAT - 1; free_at = t + LAT;
                q.push_back('{t + LAT, 1'b1, 1'b1, rh, rl});
            end
            4: begin
                busy_from = t + 1; busy_to = t + 32; free_at = t + 33;
                q.push_back('{t + 33, 1'b1, 1'b1, rh, rl});
            end
            default: free_at = t + 1;
        endcase
        next();
        start = 1'b0;
    endtask

    // Flush in the current cycle: pulses due after this cycle are cancelled.
    task automatic flush_now();
        exp_t keep[$];
        flush = 1'b1;
        foreach (q[i]) if (q[i].due <= cyc) keep.push_back(q[i]);
        q = keep;
        if (busy_to > cyc) busy_to = cyc;
        if (free_at > cyc + 1) free_at = cyc + 1;
        next();
        flush = 1'b0;
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: busy/stall every cycle, pulses against the scoreboard.
    always @(negedge clk) begin
        bit   eb;
        exp_t e;
        eb = (cyc >= busy_from) && (cyc <= busy_to);
        check("busy", 64'(busy), 64'(eb));
        check("stall", 64'(stall), 64'(eb && (start || read_hilo)));
        while (q.size() > 0 && q[0].due < cyc) begin
            check("missed_pulse_due", 64'(q[0].due), 64'(cyc));
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("write_hi", 64'(write_hi), 64'(e.wh));
            check("write_lo", 64'(write_lo), 64'(e.wl));
            if (e.wh) check("hi_data", 64'(hi_data), 64'(e.h));
            if (e.wl) check("lo_data", 64'(lo_data), 64'(e.l));
        end else begin
            check("unexpected_write", 64'({write_hi, write_lo}), 64'd0);
        end
    end

    initial begin
        int t0;
        reset = 1'b1; start = 1'b0; flush = 1'b0; read_hilo = 1'b0;
        op = 4'd0; rs_data = 32'd0; rt_data = 32'd0; hi_in = 32'd0; lo_in = 32'd0;
        repeat (3) next();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi_data", 64'(hi_data), 64'd0);
        check("reset_lo_data", 64'(lo_data), 64'd0);
        reset = 1'b0;
        free_at = cyc;
        next();

        issue(4'd4, 32'h1234_5678, 32'd0, 32'd0, 32'd0);
        issue(4'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'd0, 32'd0);
        t0 = cyc;
        issue(4'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
        while (cyc < t0 + 5) next();
        read_hilo = 1'b1;
        #1;
        check("stall_on_read", 64'(stall), 64'd1);
        next();
        issue(4'd3, 32'd7, 32'd0, 32'd0, 32'd0);
        issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
        issue(4'd6, 32'd5, 32'd7, 32'd1, 32'd2);
        issue(4'd7, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
        issue(4'd12, 32'd3, 32'd3, 32'd0, 32'd0);
        repeat (4) next();

        // DIV flushed at T+10: no pulse through T+40.
        issue(4'd2, 32'd100, 32'd7, 32'd0, 32'd0);
        t0 = free_at - 33;
        while (cyc < t0 + 10) next();
        flush_now();
        while (cyc < t0 + 41) next();

        // Second start held through the whole divide.
        issue(4'd3, 32'hDEAD_BEEF, 32'd13, 32'd0, 32'd0);
        issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        repeat (4) next();

        // Reset while the divider is at iteration 10.
        issue(4'd2, 32'h7FFF_0000, 32'd3, 32'd0, 32'd0);
        t0 = free_at - 33;
        while (cyc < t0 + 11) next();
        reset = 1'b1;
        q.delete();
        busy_to = cyc - 1;
        #1;
        check("reset_mid_busy", 64'(busy), 64'd0);
        check("reset_mid_write", 64'({write_hi, write_lo}), 64'd0);
        repeat (2) next();
        reset = 1'b0;
        free_at = cyc;
        next();

        rand_rd = 1'b1;
        for (int n = 0; n < 250; n++) begin
            issue(4'($urandom_range(0, 15)), rnd32(), rnd32(), rnd32(), rnd32());
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, 20)) next();
                flush_now();
            end
            repeat ($urandom_range(0, 3)) next();
        end
        rand_rd = 1'b0;
        repeat (40) next();
        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
